l7_fetch_decode_q: RTL and testbench
====================================

Name: l7_fetch_decode_q

Overview:
- Parametrised instruction fetch/decode front end: program counter, synchronous instruction-memory interface, decoded-instruction queue, and valid/ready output handshake.
- Successor to the single-cycle PC/ROM/decode stage. Adds configurable PC and instruction width, reset vector, 1-cycle-latency memory tolerance, back-pressure buffering, and redirect with flush of wrong-path fetches.
- Feeds the execute stage; the redirect input is driven by execute.

Parameters:
PC_W, 7, program counter / instruction address width (word addressed)
XLEN, 32, instruction width
DEPTH, 2, decoded-instruction queue entries (power of 2, >=2)
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
imem_en  out  1  fetch request this cycle
imem_addr  out  PC_W  fetch address (= current PC)
imem_rdata  in  XLEN  instruction, valid the cycle after imem_en
jmpen  in  1  redirect request
jmpa  in  PC_W  redirect target
out_valid  out  1  decoded instruction available
out_ready  in  1  consumer accepts
Iout  out  XLEN  raw instruction at queue head
PCout  out  PC_W  address of the instruction at queue head
Rs1  out  5  Iout[19:15]
Rs2  out  5  Iout[24:20]
RD  out  5  Iout[11:7]
IMM  out  20  Iout[31:12]

Behaviour:
- Reset: sampled on a clk edge with rst_n=0. Sets pc=RESET_PC, queue empty, inflight=0. During reset imem_en=0 and out_valid=0. Reset overrides jmpen.
- Decoded outputs (Iout, PCout, Rs1, Rs2, RD, IMM) are combinational from the queue head. They are driven to 0 whenever out_valid=0.
- pop = out_valid & out_ready.
- Issue rule: in cycle N, imem_en=1 iff rst_n=1, jmpen=0, and (count + inflight - pop) < DEPTH.
  - count and inflight are registered values.
  - imem_en therefore depends combinationally on out_ready.
- On issue: pc <= pc+1, mod 2^PC_W (2^PC_W-1 wraps to 0). The issued PC is carried alongside inflight.
- Response: imem_rdata is captured at the end of cycle N+1 into the queue tail with its PC, unless killed. out_valid is high from cycle N+2.
- Latency: reset released, cycle 0 issues RESET_PC, first out_valid in cycle 2. Sustained throughput is 1 instruction/cycle with out_ready=1.
- Back-pressure: with out_ready=0, issue stops once count+inflight=DEPTH. Head outputs are held stable until popped. No entry is dropped or duplicated.
- Redirect (jmpen=1 in cycle T):
  - A pop occurring in cycle T completes normally.
  - All other queue entries are flushed.
  - Any inflight response arriving in T+1 is discarded.
  - No issue occurs in T; pc <= jmpa.
  - T+1 issues jmpa; out_valid=0 in T+1 and T+2; jmpa instruction valid in T+3.
- Back-to-back redirects: each takes effect; only the last target's instructions ever appear.
- Redirect while queue full: flush frees space; issue resumes T+1.
- Simultaneous push and pop on a full queue is legal; count is unchanged.
- Queue pointers wrap modulo DEPTH.

Test Plan:
- Reset release with rom[a]=32'h002081B3+(a<<7) and out_ready=1:
  - imem_addr 0,1,2… from cycle 0.
  - out_valid from cycle 2 with PCout=0, Iout=32'h002081B3, Rs1=1, Rs2=2, RD=3, IMM=20'h00208.
  - Then one instruction/cycle, PCout incrementing.
- Back-pressure: out_ready=0 from cycle 3 for 6 cycles.
  - imem_en=0 once occupancy reaches DEPTH.
  - Head holds PCout=1.
  - On release, PCout sequence 1,2,3… with no gaps or repeats.
- Redirect: jmpen=1, jmpa=7'h40 while inflight and queue non-empty.
  - Next issue address is 0x40; out_valid low two cycles.
  - Next delivered PCout=0x40; no wrong-path PC delivered.
- Redirect coincident with pop:
  - The popped entry is delivered exactly once.
  - Subsequent PCout starts at jmpa.
- Wrap: jmpa=7'h7E.
  - Delivered PCout sequence 7E, 7F, 00, 01.
- Mid-run reset: rst_n=0 for one cycle during full flow.
  - out_valid=0 the next cycle.
  - Fetch restarts at RESET_PC; no stale instruction emerges afterwards.

Source files
------------

// File: rtl/l7_fetch_decode_q.sv
// l7_fetch_decode_q: fetch/decode front end with PC, synchronous imem port,
// decoded-instruction queue and valid/ready output with redirect flush.
module l7_fetch_decode_q #(
  parameter int              PC_W     = 7,
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            jmpen,
  input  logic [PC_W-1:0] jmpa,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Iout,
  output logic [PC_W-1:0] PCout,
  output logic [4:0]      Rs1,
  output logic [4:0]      Rs2,
  output logic [4:0]      RD,
  output logic [19:0]     IMM
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ipc_q, ipc_d;
  logic            infl_q, infl_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;

  logic [XLEN-1:0] iq_q [DEPTH];
  logic [PC_W-1:0] pq_q [DEPTH];

  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occ;

  // Head is visible only outside reset; a pop frees a slot this cycle.
  assign out_valid = rst_n & (count_q != '0);
  assign pop       = out_valid & out_ready;

  // Slots already claimed once this cycle's pop is accounted for.
  assign occ = {1'b0, count_q}
             + {{CW{1'b0}}, infl_q}
             - {{CW{1'b0}}, pop};

  assign issue     = rst_n & ~jmpen & (occ < DEPTH_C);
  assign imem_en   = issue;
  assign imem_addr = pc_q;

  // A response landing during a redirect is wrong-path and dropped.
  assign push = infl_q & ~jmpen;

  // Next-state for PC, inflight tracker and queue bookkeeping.
  always_comb begin
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    infl_d  = issue;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (issue) begin
      pc_d  = pc_q + PC_W'(1);
      ipc_d = pc_q;
    end
    if (jmpen) begin
      pc_d    = jmpa;
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      if (push) begin
        wr_d = wr_q + AW'(1);
      end
      count_d = count_q
              + {{AW{1'b0}}, push}
              - {{AW{1'b0}}, pop};
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      ipc_q   <= RESET_PC;
      infl_q  <= 1'b0;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      infl_q  <= infl_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Queue storage; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      iq_q[wr_q] <= imem_rdata;
      pq_q[wr_q] <= ipc_q;
    end
  end

  // Head decode, forced to zero when nothing is presented.
  always_comb begin
    Iout  = '0;
    PCout = '0;
    if (out_valid) begin
      Iout  = iq_q[rd_q];
      PCout = pq_q[rd_q];
    end
  end

  assign Rs1 = Iout[19:15];
  assign Rs2 = Iout[24:20];
  assign RD  = Iout[11:7];
  assign IMM = Iout[31:12];

endmodule

// File: tb/tb_l7_fetch_decode_q.sv
// tb_l7_fetch_decode_q: scoreboard bench for the fetch/decode queue.
// Expected PCs are queued on issue and compared as the DUT delivers.
module tb_l7_fetch_decode_q;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_en;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        jmpen;
  logic [6:0]  jmpa;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Iout;
  logic [6:0]  PCout;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [4:0]  RD;
  logic [19:0] IMM;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [6:0] mq[$];
  logic [6:0] got[$];
  logic [6:0] m_pc;
  logic [6:0] m_ipc;
  logic       m_infl;
  logic       pend_v;
  logic [6:0] pend_a;

  l7_fetch_decode_q #(
    .PC_W(7), .XLEN(32), .DEPTH(DEPTH), .RESET_PC(7'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .jmpen(jmpen), .jmpa(jmpa),
    .out_valid(out_valid), .out_ready(out_ready),
    .Iout(Iout), .PCout(PCout),
    .Rs1(Rs1), .Rs2(Rs2), .RD(RD), .IMM(IMM)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [6:0] a);
    return 32'h002081B3 + ({25'b0, a} << 7);
  endfunction

  // One clock: drive inputs, serve memory, compare against scoreboard.
  task automatic step(input logic r, input logic j,
                      input logic [6:0] ja, input logic rdy);
    logic        ev;
    logic        ep;
    logic        ee;
    int          occ;
    logic [6:0]  e;
    logic [31:0] ei;
    @(negedge clk);
    rst_n      = r;
    jmpen      = j;
    jmpa       = ja;
    out_ready  = rdy;
    imem_rdata = pend_v ? rom(pend_a) : 32'hFFFF_FFFF;
    #1;
    ev  = r && (mq.size() > 0);
    ep  = ev && rdy;
    occ = mq.size() + int'(m_infl) - int'(ep);
    ee  = r && !j && (occ < DEPTH);
    checks++;
    if (out_valid !== ev) begin
      errors++;
      $display("FAIL sb_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev);
    end
    checks++;
    if (imem_en !== ee) begin
      errors++;
      $display("FAIL sb_imem_en cyc=%0d got=%b exp=%b", cyc, imem_en, ee);
    end
    if (ee) begin
      checks++;
      if (imem_addr !== m_pc) begin
        errors++;
        $display("FAIL sb_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc);
      end
    end
    if (ev) begin
      e  = mq[0];
      ei = rom(e);
      checks++;
      if (PCout !== e || Iout !== ei) begin
        errors++;
        $display("FAIL sb_head cyc=%0d pc=%h/%h ins=%h/%h",
                 cyc, PCout, e, Iout, ei);
      end
      checks++;
      if (Rs1 !== ei[19:15] || Rs2 !== ei[24:20] ||
          RD !== ei[11:7] || IMM !== ei[31:12]) begin
        errors++;
        $display("FAIL sb_fields cyc=%0d rs1=%0d rs2=%0d rd=%0d imm=%h",
                 cyc, Rs1, Rs2, RD, IMM);
      end
    end else begin
      checks++;
      if (Iout !== '0 || PCout !== '0 || IMM !== '0) begin
        errors++;
        $display("FAIL sb_zero cyc=%0d pc=%h ins=%h", cyc, PCout, Iout);
      end
    end
    if (out_valid === 1'b1 && rdy) got.push_back(PCout);
    pend_v = (imem_en === 1'b1);
    pend_a = imem_addr;
    if (!r) begin
      mq.delete();
      m_pc   = 7'd0;
      m_infl = 1'b0;
    end else begin
      if (ep) void'(mq.pop_front());
      if (j) begin
        mq.delete();
        m_pc = ja;
      end else if (m_infl) begin
        mq.push_back(m_ipc);
      end
      if (ee) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 7'd1;
      end
      m_infl = ee;
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 7'd0, 1'b1);
    step(1'b0, 1'b0, 7'd0, 1'b1);
    got.delete();
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 7'h33, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || imem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs valid=%b en=%b exp=0/0", out_valid, imem_en);
    end
    step(1'b0, 1'b0, 7'd0, 1'b1);
    got.delete();
  endtask

  task automatic test_release();
    do_reset();
    step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 7'd0) begin
      errors++;
      $display("FAIL rel_c0 en=%b addr=%h exp=1/00", imem_en, imem_addr);
    end
    step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 7'd1) begin
      errors++;
      $display("FAIL rel_c1 valid=%b addr=%h exp=0/01", out_valid, imem_addr);
    end
    step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || PCout !== 7'd0 || Iout !== 32'h002081B3) begin
      errors++;
      $display("FAIL rel_first valid=%b pc=%h ins=%h exp=1/00/002081b3",
               out_valid, PCout, Iout);
    end
    checks++;
    if (Rs1 !== 5'd1 || Rs2 !== 5'd2 || RD !== 5'd3 || IMM !== 20'h00208) begin
      errors++;
      $display("FAIL rel_fields rs1=%0d rs2=%0d rd=%0d imm=%h exp=1/2/3/00208",
               Rs1, Rs2, RD, IMM);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (got.size() != 7) begin
      errors++;
      $display("FAIL rel_rate got=%0d exp=7", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 7'(i)) begin
        errors++;
        $display("FAIL rel_seq idx=%0d got=%h exp=%h", i, got[i], 7'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 7'd0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || PCout !== 7'd1) begin
        errors++;
        $display("FAIL bp_hold i=%0d valid=%b pc=%h exp=1/01",
                 i, out_valid, PCout);
      end
    end
    checks++;
    if (imem_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall en=%b exp=0", imem_en);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (got.size() < 8) begin
      errors++;
      $display("FAIL bp_count got=%0d exp>=8", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 7'(i)) begin
        errors++;
        $display("FAIL bp_seq idx=%0d got=%h exp=%h", i, got[i], 7'(i));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    got.delete();
    step(1'b1, 1'b1, 7'h40, 1'b0);
    step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 7'h40 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_t1 en=%b addr=%h valid=%b exp=1/40/0",
               imem_en, imem_addr, out_valid);
    end
    step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_t2 valid=%b exp=0", out_valid);
    end
    step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || PCout !== 7'h40) begin
      errors++;
      $display("FAIL rd_t3 valid=%b pc=%h exp=1/40", out_valid, PCout);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 7'h40 + 7'(i)) begin
        errors++;
        $display("FAIL rd_seq idx=%0d got=%h exp=%h",
                 i, got[i], 7'h40 + 7'(i));
      end
    end
  endtask

  task automatic test_redirect_pop();
    logic [6:0] exp_l [6];
    exp_l = '{7'h00, 7'h01, 7'h02, 7'h20, 7'h21, 7'h22};
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    step(1'b1, 1'b1, 7'h20, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (got.size() < 6) begin
      errors++;
      $display("FAIL rp_count got=%0d exp>=6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL rp_seq idx=%0d got=%h exp=%h", i, got[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    step(1'b1, 1'b1, 7'h10, 1'b1);
    got.delete();
    step(1'b1, 1'b1, 7'h30, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (got.size() < 4) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp>=4", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 7'h30 + 7'(i)) begin
        errors++;
        $display("FAIL b2b_seq idx=%0d got=%h exp=%h",
                 i, got[i], 7'h30 + 7'(i));
      end
    end
  endtask

  task automatic test_wrap();
    logic [6:0] exp_l [4];
    exp_l = '{7'h7E, 7'h7F, 7'h00, 7'h01};
    do_reset();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    step(1'b1, 1'b1, 7'h7E, 1'b1);
    got.delete();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (got.size() < 4) begin
      errors++;
      $display("FAIL wrap_count got=%0d exp>=4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL wrap_seq idx=%0d got=%h exp=%h", i, got[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    step(1'b0, 1'b0, 7'd0, 1'b1);
    got.delete();
    step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 7'd0) begin
      errors++;
      $display("FAIL mr_restart valid=%b en=%b addr=%h exp=0/1/00",
               out_valid, imem_en, imem_addr);
    end
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (got.size() < 5) begin
      errors++;
      $display("FAIL mr_count got=%0d exp>=5", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 7'(i)) begin
        errors++;
        $display("FAIL mr_seq idx=%0d got=%h exp=%h", i, got[i], 7'(i));
      end
    end
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    jmpen      = 1'b0;
    jmpa       = 7'd0;
    out_ready  = 1'b0;
    imem_rdata = 32'd0;
    pend_v     = 1'b0;
    pend_a     = 7'd0;
    m_pc       = 7'd0;
    m_ipc      = 7'd0;
    m_infl     = 1'b0;
    test_reset();
    test_release();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
